// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: streams len bytes from the message RAM starting at base to the UART TX
// through a 2-entry prefetch FIFO that hides the RAM's one-cycle read latency.
module uart_msg_streamer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              read_en,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);
  localparam int LW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0] len_q, len_d, issue_q, issue_d, sent_q, sent_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, inflight_q, inflight_d;
  logic [1:0] count_q, count_d, occ;
  logic pop, credit;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    sent_d = sent_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fifo_d = fifo_q;
    tx_valid = count_q != 2'd0;
    tx_data = fifo_q[rd_ptr_q];
    pop = tx_valid && tx_ready;
    occ = count_q + 2'(inflight_q);
    // a slot freed by this cycle's pop can be refilled by a read issued in the same cycle
    credit = occ < 2'd2 || (occ == 2'd2 && pop);
    read_en = state_q == RUN && issue_q < len_q && credit;
    raddr = read_en ? base_q + issue_q[ADDR_W-1:0] : '0;
    inflight_d = read_en;
    issue_d = issue_q + LW'(read_en);
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = rdata;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      sent_d = sent_q + LW'(1);
    end
    count_d = count_q + 2'(inflight_q) - 2'(pop);
    if (state_q == IDLE && start) begin
      state_d = len == '0 ? FINISH : RUN;
      base_d = base;
      len_d = len;
      issue_d = '0;
      sent_d = '0;
    end else if (state_q == RUN && pop && sent_d == len_q) begin
      state_d = FINISH;
    end else if (state_q == FINISH) begin
      state_d = IDLE;
    end
    busy = state_q != IDLE;
    done = state_q == FINISH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      issue_q <= '0;
      sent_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      inflight_q <= 1'b0;
      count_q <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      issue_q <= issue_d;
      sent_q <= sent_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
    end
  end
endmodule

// File: tb/tb_uart_msg_streamer.sv
// tb_uart_msg_streamer: directed transfers; expected bytes/addresses queued at start,
// a negedge monitor pops and compares on every handshake and read strobe.
module tb_uart_msg_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [8:0] base = '0;
  logic [9:0] len = '0;
  logic read_en, tx_valid, busy, done;
  logic tx_ready = 1'b1;
  logic [8:0] raddr;
  logic [7:0] rdata = '0;
  logic [7:0] tx_data;
  logic [7:0] mem [512];
  int tests = 0, fails = 0;
  int cyc = 0, c0 = 0, rel;
  int mode = 0;
  bit active = 0;
  int rd_cnt, rd_first, rd_last, tv_cnt, tv_first, hs_cnt, hs_last, busy_cnt, done_cnt, done_cyc;
  bit stalled = 0;
  logic [7:0] held;
  int dq[$];
  int aq[$];
  uart_msg_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .read_en(read_en), .raddr(raddr), .rdata(rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (read_en) rdata <= mem[raddr];
  always @(posedge clk) begin
    #1;
    tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b0;
  end
  task automatic check(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else if (active) begin
      rel = cyc - c0 + 1;
      check("occupancy_le_2", int'(dut.count_q) + int'(dut.inflight_q) <= 2, 1);
      if (read_en) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = rel;
        rd_last = rel;
        check("read_en_while_busy", busy, 1);
        if (aq.size() == 0) check("extra_read", 1, 0);
        else check("raddr", raddr, aq.pop_front());
      end
      if (tx_valid) begin
        tv_cnt++;
        if (tv_first == 0) tv_first = rel;
      end
      if (stalled) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, held);
      end
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        hs_last = rel;
        if (dq.size() == 0) check("extra_byte", 1, 0);
        else check("byte", tx_data, dq.pop_front());
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
    end
  end
  task automatic go(input int b, input int l, input int m);
    dq.delete();
    aq.delete();
    {rd_cnt, rd_first, rd_last, tv_cnt, tv_first, hs_cnt, hs_last, busy_cnt, done_cnt, done_cyc} = '0;
    mode = m;
    for (int i = 0; i < l; i++) begin
      aq.push_back((b + i) % 512);
      dq.push_back(int'(mem[(b + i) % 512]));
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    base = 9'(b);
    len = 10'(l);
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    base = 9'h1aa;
    len = 10'd7;
    active = 1;
  endtask
  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    check("done_count", done_cnt, 1);
    check("bytes_left", dq.size(), 0);
    check("addrs_left", aq.size(), 0);
    check("hs_total", hs_cnt, rd_cnt);
  endtask
  task automatic check_zero(input string n);
    check({n, "_read_en"}, read_en, 0);
    check({n, "_raddr"}, raddr, 0);
    check({n, "_tx_valid"}, tx_valid, 0);
    check({n, "_tx_data"}, tx_data, 0);
    check({n, "_busy"}, busy, 0);
    check({n, "_done"}, done, 0);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
    mem[16] = 8'hA1;
    mem[17] = 8'hB2;
    mem[18] = 8'hC3;
    mem[19] = 8'hD4;
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    go(16, 4, 0);
    wait_done(50);
    check("basic_rd_first", rd_first, 1);
    check("basic_rd_last", rd_last, 4);
    check("basic_rd_cnt", rd_cnt, 4);
    check("basic_tv_first", tv_first, 3);
    check("basic_hs_last", hs_last, 6);
    check("basic_hs_cnt", hs_cnt, 4);
    check("basic_done_cyc", done_cyc, 7);
    check("basic_busy_cnt", busy_cnt, 7);
    go(16, 4, 1);
    wait_done(100);
    check("bp_hs_cnt", hs_cnt, 4);
    go(510, 4, 0);
    wait_done(50);
    check("wrap_rd_cnt", rd_cnt, 4);
    check("wrap_done_cyc", done_cyc, 7);
    go(0, 0, 0);
    wait_done(20);
    check("len0_done_cyc", done_cyc, 1);
    check("len0_rd_cnt", rd_cnt, 0);
    check("len0_tv_cnt", tv_cnt, 0);
    check("len0_busy_cnt", busy_cnt, 1);
    go(5, 512, 0);
    wait_done(2000);
    check("len512_hs_cnt", hs_cnt, 512);
    check("len512_done_cyc", done_cyc, 515);
    go(16, 4, 0);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = 9'h40;
    len = 10'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(50);
    check("busy_start_hs_cnt", hs_cnt, 4);
    check("busy_start_done_cyc", done_cyc, 7);
    go(0, 8, 2);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("midreset");
    active = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("midreset_no_done", done, 0);
    go(0, 3, 0);
    wait_done(50);
    check("after_reset_hs_cnt", hs_cnt, 3);
    check("after_reset_done_cyc", done_cyc, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
